present_sbox_layer_dup_detect: RTL and testbench
================================================

Name: present_sbox_layer_dup_detect

Overview:
Parametrised PRESENT S-box layer with round-key addition and duplication-based fault detection. It processes NUM_SBOX nibbles per transaction over a valid/ready handshake. In SPATIAL mode two parallel S-box copies are compared; in TEMPORAL mode one S-box bank computes the same input twice on successive cycles. On mismatch the output word is forced to zero, a sticky fault flag is set and a saturating error counter increments. The block sits between the state register and the pLayer of a fault-hardened PRESENT round datapath.

Parameters:
NUM_SBOX, 4, number of 4-bit S-boxes; STATE_W = 4*NUM_SBOX
TEMPORAL, 0, 0 = spatial duplication (latency 1); 1 = temporal recomputation (latency 3)
ERR_CNT_W, 8, width of the saturating mismatch counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
io_in_valid  in  1  input word valid
io_in_ready  out  1  block can accept input
io_state  in  STATE_W  state nibbles; nibble i = bits [4i+3:4i]
io_key  in  STATE_W  round-key slice XORed after the S-box
io_inj_mask  in  STATE_W  verification fault-injection mask XORed into the redundant copy's S-box input; tied to 0 in product builds
io_out_valid  out  1  output word valid
io_out_ready  in  1  downstream accepts output
io_out  out  STATE_W  S(state)^key, or all-zero on detected fault
io_fault  out  1  sticky fault flag
io_fault_clr  in  1  clears io_fault (not the counter)
io_err_cnt  out  ERR_CNT_W  number of detected mismatches, saturating

Behaviour:
- One clock domain, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values: io_out_valid=0, io_out=0, io_fault=0, io_err_cnt=0, FSM=IDLE. io_in_ready follows the ready equations below.
- S-box table (hex, index 0..F): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2. Each nibble is independent.
- Result per word: R_A = S(state)^key, R_B = S(state^inj_mask)^key. match = (R_A == R_B) over the whole word. io_out = match ? R_A : 0.
- Spatial mode (TEMPORAL=0):
  - Single output register. io_in_ready = !io_out_valid || io_out_ready.
  - A transfer at edge t loads io_out at t, so io_out_valid is high from t+1.
  - With no new transfer, out_valid clears when out_ready=1. Back-to-back transfers give 1 word/cycle.
  - While out_valid=1 and out_ready=0, io_out is held stable.
- Temporal mode (TEMPORAL=1), FSM IDLE -> PASS_A -> PASS_B -> OUT:
  - IDLE: io_in_ready=1. On transfer, capture state/key/mask and go to PASS_A.
  - PASS_A: compute R_A into an internal register, go to PASS_B.
  - PASS_B: compute R_B using the captured mask, compare, load io_out, go to OUT.
  - OUT: io_out_valid=1. On out_ready, go to IDLE.
  - io_in_ready is 0 outside IDLE. Accept at edge t gives out_valid at t+3. Throughput is at most 1 word per 4 cycles.
- Fault logic (both modes), evaluated when the output register loads:
  - On mismatch: io_fault <= 1 and io_err_cnt increments, saturating at all-ones.
  - io_fault_clr=1 clears io_fault on the next edge. If fault_clr and a new mismatch land on the same edge, set wins.
- The zeroing decision is per word, not per nibble.
- Reset asserted mid-operation aborts any in-flight word. No output is produced for it and counters and flags return to reset values.
- Unused handshake inputs are ignored while reset is high.

Decomposition:
- Package present_dup_pkg holds:
  - PRESENT_SBOX constant array (16 x 4 bit)
  - mode constants SPATIAL/TEMPORAL
  - FSM state enum {IDLE, PASS_A, PASS_B, OUT}
  - function nibble_sbox
- Sub-module present_sbox_keyadd_bank: combinational NUM_SBOX-wide S-box plus key XOR.
  - Instantiated twice in spatial mode, once (time-shared) in temporal mode.
- Top level holds the handshake, FSM, comparator, fault flag and counter.

Test Plan:
- NUM_SBOX=4, TEMPORAL=0, state=0x0000, key=0x0000, mask=0 -> io_out=0xCCCC one cycle after the transfer, io_fault=0, io_err_cnt=0.
- state=0x1234, key=0x00FF, mask=0, both modes -> io_out=0x5646. Spatial latency 1; temporal latency 3 with io_in_ready low for 3 cycles.
- state=0x1234, key=0x00FF, mask=0x0010 -> io_out=0x0000, io_fault=1, io_err_cnt=1. Then pulse io_fault_clr with no mismatch -> io_fault=0, io_err_cnt stays 1.
- Spatial back-pressure: transfer 0xFFFF/key 0 then hold out_ready=0 for 5 cycles -> io_out=0x2222 stable, io_in_ready=0; release -> 1 word/cycle streaming resumes.
- ERR_CNT_W=2: 5 consecutive mismatching words -> io_err_cnt saturates at 3. fault_clr asserted on the same edge as a mismatch -> io_fault stays 1.
- Temporal mode: assert reset during PASS_B -> no io_out_valid for that word, io_fault=0, io_err_cnt=0, FSM=IDLE, io_in_ready=1 on the next cycle.

Source files
------------

// File: rtl/present_sbox_layer_dup_detect_pkg.sv
// Shared constants and helpers for the duplicated PRESENT S-box layer.
package present_dup_pkg;

  // Entry i is S(i); index 0 is the leftmost element.
  localparam logic [0:15][3:0] PRESENT_SBOX = {
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam int MODE_SPATIAL  = 0;
  localparam int MODE_TEMPORAL = 1;

  typedef enum logic [1:0] {IDLE, PASS_A, PASS_B, OUT} fsm_e;

  function automatic logic [3:0] nibble_sbox(input logic [3:0] x);
    return PRESENT_SBOX[x];
  endfunction

endpackage

// File: rtl/present_sbox_layer_dup_detect_if.sv
// Handshake, data and fault-status bundle of the duplicated S-box layer.
interface present_sbox_layer_dup_detect_if #(
  parameter int NUM_SBOX  = 4,
  parameter int ERR_CNT_W = 8
);
  localparam int STATE_W = 4 * NUM_SBOX;

  logic               io_in_valid;
  logic               io_in_ready;
  logic [STATE_W-1:0] io_state;
  logic [STATE_W-1:0] io_key;
  logic [STATE_W-1:0] io_inj_mask;
  logic               io_out_valid;
  logic               io_out_ready;
  logic [STATE_W-1:0] io_out;
  logic               io_fault;
  logic               io_fault_clr;
  logic [ERR_CNT_W-1:0] io_err_cnt;

  modport slave (
    input  io_in_valid, io_state, io_key, io_inj_mask, io_out_ready, io_fault_clr,
    output io_in_ready, io_out_valid, io_out, io_fault, io_err_cnt
  );

  modport master (
    output io_in_valid, io_state, io_key, io_inj_mask, io_out_ready, io_fault_clr,
    input  io_in_ready, io_out_valid, io_out, io_fault, io_err_cnt
  );
endinterface

// File: rtl/present_sbox_layer_dup_detect_bank.sv
// Combinational NUM_SBOX-wide PRESENT S-box layer followed by key XOR.
module present_sbox_keyadd_bank
  import present_dup_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic [4*NUM_SBOX-1:0] i_state,
  input  logic [4*NUM_SBOX-1:0] i_key,
  output logic [4*NUM_SBOX-1:0] o_res
);
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    assign o_res[4*g +: 4] = nibble_sbox(i_state[4*g +: 4]) ^ i_key[4*g +: 4];
  end
endmodule

// File: rtl/present_sbox_layer_dup_detect.sv
// PRESENT S-box/key-add layer with spatial or temporal duplication; any word-level
// disagreement zeroes the output, sets a sticky flag and bumps a saturating counter.
module present_sbox_layer_dup_detect
  import present_dup_pkg::*;
#(
  parameter int NUM_SBOX  = 4,
  parameter int TEMPORAL  = 0,
  parameter int ERR_CNT_W = 8
) (
  input logic clock,
  input logic reset,
  present_sbox_layer_dup_detect_if.slave bus
);
  localparam int STATE_W = 4 * NUM_SBOX;

  logic                 w_in_ready;
  logic                 w_load;
  logic                 w_match;
  logic                 r_out_valid;
  logic [STATE_W-1:0]   r_out;
  logic                 r_fault;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  if (TEMPORAL == MODE_SPATIAL) begin : g_sp
    logic [STATE_W-1:0] w_ra, w_rb;

    present_sbox_keyadd_bank #(.NUM_SBOX(NUM_SBOX)) u_bank_a (
      .i_state(bus.io_state), .i_key(bus.io_key), .o_res(w_ra));
    present_sbox_keyadd_bank #(.NUM_SBOX(NUM_SBOX)) u_bank_b (
      .i_state(bus.io_state ^ bus.io_inj_mask), .i_key(bus.io_key), .o_res(w_rb));

    assign w_in_ready = !r_out_valid || bus.io_out_ready;
    assign w_load     = bus.io_in_valid && w_in_ready;
    assign w_match    = (w_ra == w_rb);

    always_ff @(posedge clock) begin
      if (reset) begin
        r_out_valid <= 1'b0;
        r_out       <= '0;
      end else if (w_load) begin
        r_out_valid <= 1'b1;
        r_out       <= w_match ? w_ra : '0;
      end else if (bus.io_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end else begin : g_tp
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_PASS_A = PASS_A;
    localparam logic [1:0] S_PASS_B = PASS_B;
    localparam logic [1:0] S_OUT    = OUT;

    logic [1:0]         r_fsm;
    logic [STATE_W-1:0] r_st, r_key, r_mask, r_ra;
    logic [STATE_W-1:0] w_bank_in, w_r;

    // One bank is time-shared: clean input on PASS_A, mask-perturbed input on PASS_B.
    assign w_bank_in = (r_fsm == S_PASS_B) ? (r_st ^ r_mask) : r_st;

    present_sbox_keyadd_bank #(.NUM_SBOX(NUM_SBOX)) u_bank (
      .i_state(w_bank_in), .i_key(r_key), .o_res(w_r));

    assign w_in_ready = (r_fsm == S_IDLE);
    assign w_load     = (r_fsm == S_PASS_B);
    assign w_match    = (r_ra == w_r);

    always_ff @(posedge clock) begin
      if (reset) begin
        r_fsm       <= S_IDLE;
        r_out_valid <= 1'b0;
        r_out       <= '0;
      end else begin
        case (r_fsm)
          S_IDLE: if (bus.io_in_valid) begin
            r_st   <= bus.io_state;
            r_key  <= bus.io_key;
            r_mask <= bus.io_inj_mask;
            r_fsm  <= S_PASS_A;
          end
          S_PASS_A: begin
            r_ra  <= w_r;
            r_fsm <= S_PASS_B;
          end
          S_PASS_B: begin
            r_out       <= w_match ? r_ra : '0;
            r_out_valid <= 1'b1;
            r_fsm       <= S_OUT;
          end
          default: if (bus.io_out_ready) begin
            r_out_valid <= 1'b0;
            r_fsm       <= S_IDLE;
          end
        endcase
      end
    end
  end

  // A mismatch landing together with a clear keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fault   <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_load && !w_match) begin
      r_fault <= 1'b1;
      if (r_err_cnt != {ERR_CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end else if (bus.io_fault_clr) begin
      r_fault <= 1'b0;
    end
  end

  assign bus.io_in_ready  = w_in_ready;
  assign bus.io_out_valid = r_out_valid;
  assign bus.io_out       = r_out;
  assign bus.io_fault     = r_fault;
  assign bus.io_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_present_sbox_layer_dup_detect.sv
// Drives a spatial (2-bit counter) and a temporal (8-bit counter) instance with shared
// stimulus and checks both against a word-level model of the layer.
module tb_present_sbox_layer_dup_detect;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         d_iv, d_ordy, d_clr;
  logic [W-1:0] d_st, d_key, d_mask;

  present_sbox_layer_dup_detect_if #(.NUM_SBOX(N), .ERR_CNT_W(2)) bs ();
  present_sbox_layer_dup_detect_if #(.NUM_SBOX(N), .ERR_CNT_W(8)) bt ();

  assign bs.io_in_valid = d_iv;   assign bt.io_in_valid = d_iv;
  assign bs.io_state = d_st;      assign bt.io_state = d_st;
  assign bs.io_key = d_key;       assign bt.io_key = d_key;
  assign bs.io_inj_mask = d_mask; assign bt.io_inj_mask = d_mask;
  assign bs.io_out_ready = d_ordy; assign bt.io_out_ready = d_ordy;
  assign bs.io_fault_clr = d_clr; assign bt.io_fault_clr = d_clr;

  present_sbox_layer_dup_detect #(.NUM_SBOX(N), .TEMPORAL(0), .ERR_CNT_W(2)) u_sp (
    .clock(clock), .reset(reset), .bus(bs));
  present_sbox_layer_dup_detect #(.NUM_SBOX(N), .TEMPORAL(1), .ERR_CNT_W(8)) u_tp (
    .clock(clock), .reset(reset), .bus(bt));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference S-box and word function.
  logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [W-1:0] layer(input logic [W-1:0] s, input logic [W-1:0] k);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[4*i +: 4] = SB[s[4*i +: 4]] ^ k[4*i +: 4];
    return r;
  endfunction

  // Model: at most one word in flight per instance; ld = edge index at which it loads.
  bit           has [2];
  logic [W-1:0] mw  [2];
  bit           mm  [2];
  int           ld  [2];
  bit           mf  [2];
  int           mc  [2];
  int           e = 0;
  int           CMAX [2] = '{3, 255};

  initial forever begin
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        has[d] = 0; mf[d] = 0; mc[d] = 0;
      end else begin
        bit v, rdy;
        logic [W-1:0] ra, rb;
        v   = has[d] && ld[d] < e;
        rdy = (d == 1) ? !has[d] : (!v || d_ordy);
        if (v && d_ordy) has[d] = 0;
        if (d_iv && rdy) begin
          ra = layer(d_st, d_key);
          rb = layer(d_st ^ d_mask, d_key);
          has[d] = 1;
          mm[d]  = (ra != rb);
          mw[d]  = mm[d] ? '0 : ra;
          ld[d]  = e + ((d == 1) ? 2 : 0);
        end
        if (has[d] && ld[d] == e && mm[d]) begin
          mf[d] = 1;
          if (mc[d] < CMAX[d]) mc[d]++;
        end else if (d_clr) mf[d] = 0;
      end
    end
    e++;
  end

  task automatic cmp_dut(input int d, input logic rdy, input logic ov, input logic [W-1:0] o,
                         input logic f, input logic [7:0] c);
    string p;
    bit v;
    p = (d == 1) ? "tp" : "sp";
    v = has[d] && ld[d] < e;
    chk({p, "_out_valid"}, 32'(ov), 32'(v));
    chk({p, "_in_ready"}, 32'(rdy), (d == 1) ? 32'(!has[d]) : 32'(!v || d_ordy));
    if (v) chk({p, "_out"}, 32'(o), 32'(mw[d]));
    chk({p, "_fault"}, 32'(f), 32'(mf[d]));
    chk({p, "_err_cnt"}, 32'(c), 32'(mc[d]));
  endtask

  initial forever begin
    @(negedge clock);
    if (e > 0) begin
      cmp_dut(0, bs.io_in_ready, bs.io_out_valid, bs.io_out, bs.io_fault, 8'(bs.io_err_cnt));
      cmp_dut(1, bt.io_in_ready, bt.io_out_valid, bt.io_out, bt.io_fault, bt.io_err_cnt);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; d_iv = 0; d_ordy = 1; d_clr = 0; d_st = '0; d_key = '0; d_mask = '0;
    repeat (3) step();
    neg();
    chk("rst_sp_out", 32'(bs.io_out), 32'h0);
    chk("rst_sp_fault", 32'(bs.io_fault), 32'h0);
    chk("rst_tp_out_valid", 32'(bt.io_out_valid), 32'h0);
    chk("rst_tp_err_cnt", 32'(bt.io_err_cnt), 32'h0);
    step();

    // All-zero input: S(0)=C in every nibble.
    reset = 1'b0; d_iv = 1;
    step(); d_iv = 0;
    neg();
    chk("a_sp_out", 32'(bs.io_out), 32'hCCCC);
    chk("a_sp_valid", 32'(bs.io_out_valid), 32'h1);
    chk("a_sp_err_cnt", 32'(bs.io_err_cnt), 32'h0);
    step(); step(); neg();
    chk("a_tp_out", 32'(bt.io_out), 32'hCCCC);
    step(); step();

    // 0x1234 / key 0x00FF -> 0x5646, temporal ready low for three cycles.
    d_iv = 1; d_st = 16'h1234; d_key = 16'h00FF;
    step(); d_iv = 0;
    neg();
    chk("b_sp_out", 32'(bs.io_out), 32'h5646);
    chk("b_tp_ready1", 32'(bt.io_in_ready), 32'h0);
    step(); neg();
    chk("b_tp_ready2", 32'(bt.io_in_ready), 32'h0);
    chk("b_tp_valid2", 32'(bt.io_out_valid), 32'h0);
    step(); neg();
    chk("b_tp_ready3", 32'(bt.io_in_ready), 32'h0);
    chk("b_tp_valid3", 32'(bt.io_out_valid), 32'h1);
    chk("b_tp_out", 32'(bt.io_out), 32'h5646);
    step(); neg();
    chk("b_tp_ready4", 32'(bt.io_in_ready), 32'h1);
    step();

    // Injected fault on nibble 1, then a clean clear pulse.
    d_iv = 1; d_mask = 16'h0010;
    step(); d_iv = 0; d_mask = '0;
    neg();
    chk("c_sp_out", 32'(bs.io_out), 32'h0);
    chk("c_sp_fault", 32'(bs.io_fault), 32'h1);
    chk("c_sp_err_cnt", 32'(bs.io_err_cnt), 32'h1);
    step(); step(); neg();
    chk("c_tp_out", 32'(bt.io_out), 32'h0);
    chk("c_tp_err_cnt", 32'(bt.io_err_cnt), 32'h1);
    step();
    d_clr = 1;
    step(); d_clr = 0;
    neg();
    chk("c_sp_fault_clr", 32'(bs.io_fault), 32'h0);
    chk("c_sp_err_cnt_kept", 32'(bs.io_err_cnt), 32'h1);
    chk("c_tp_fault_clr", 32'(bt.io_fault), 32'h0);
    step();

    // Back-pressure on 0xFFFF -> 0x2222, then streaming.
    d_ordy = 0; d_iv = 1; d_st = 16'hFFFF; d_key = '0;
    step(); d_iv = 0;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("d_sp_hold_out", 32'(bs.io_out), 32'h2222);
      chk("d_sp_hold_ready", 32'(bs.io_in_ready), 32'h0);
      step();
    end
    d_ordy = 1; d_iv = 1;
    for (int i = 0; i < 6; i++) begin
      d_st = 16'($urandom); d_key = 16'($urandom);
      step(); neg();
      chk("d_sp_stream_valid", 32'(bs.io_out_valid), 32'h1);
      chk("d_sp_stream_ready", 32'(bs.io_in_ready), 32'h1);
    end

    // Five mismatching words with clear held: counter saturates, flag stays set.
    d_mask = 16'h0010; d_clr = 1;
    for (int i = 0; i < 5; i++) begin
      d_st = 16'($urandom);
      step();
    end
    d_iv = 0; d_clr = 0; d_mask = '0;
    neg();
    chk("e_sp_err_sat", 32'(bs.io_err_cnt), 32'h3);
    chk("e_sp_fault_set_wins", 32'(bs.io_fault), 32'h1);

    // Reset while the temporal instance sits in PASS_B.
    repeat (4) step();
    d_iv = 1; d_st = 16'h1234; d_mask = 16'h0010;
    step(); d_iv = 0; d_mask = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    neg();
    chk("f_tp_valid", 32'(bt.io_out_valid), 32'h0);
    chk("f_tp_fault", 32'(bt.io_fault), 32'h0);
    chk("f_tp_err_cnt", 32'(bt.io_err_cnt), 32'h0);
    chk("f_tp_ready", 32'(bt.io_in_ready), 32'h1);
    step(); neg();
    chk("f_tp_valid_after", 32'(bt.io_out_valid), 32'h0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset  = ($urandom_range(0, 99) == 0);
      d_iv   = ($urandom_range(0, 3) != 0);
      d_st   = 16'($urandom);
      d_key  = 16'($urandom);
      d_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      d_ordy = ($urandom_range(0, 3) != 0);
      d_clr  = ($urandom_range(0, 15) == 0);
      step();
    end
    reset = 1'b0; d_iv = 0; d_ordy = 1;
    step(); neg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
